// File: rtl/reduct_pkg.sv
// Shared types and helpers for the reduction datapath: FSM state, operator names
// and the identity value each operator folds from.
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif

package reduct_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  // Operator names are packed strings so they compare cleanly in constant context.
  localparam logic [23:0] OP_AND = "and";
  localparam logic [23:0] OP_OR  = "or";
  localparam logic [23:0] OP_XOR = "xor";

  localparam int IDENT_MAX_W = 256;

  function automatic logic [IDENT_MAX_W-1:0] identity(input logic [23:0] ope, input int data);
    if (ope == OP_AND) begin
      identity = {IDENT_MAX_W{1'b1}} >> (IDENT_MAX_W - data);
    end else begin
      identity = '0;
    end
  endfunction

endpackage

// File: rtl/reduct_op.sv
// Two-input DATA-wide bitwise operator selected by OPE; shared with the tree reducer.
module reduct_op
  import reduct_pkg::*;
#(
  parameter logic [23:0] OPE  = OP_XOR,
  parameter int          DATA = 16
) (
  input  logic [DATA-1:0] a,
  input  logic [DATA-1:0] b,
  output logic [DATA-1:0] y
);

  generate
    if (OPE == OP_AND) begin : g_and
      assign y = a & b;
    end else if (OPE == OP_OR) begin : g_or
      assign y = a | b;
    end else if (OPE == OP_XOR) begin : g_xor
      assign y = a ^ b;
    end else begin : g_bad
      $error("reduct_op: unsupported operator %s", OPE);
      assign y = a ^ b;
    end
  endgenerate

endmodule

// File: rtl/reduct_stream.sv
// Serial reducer: folds IN valid/ready beats with OPE and presents the (optionally
// inverted) result on a valid/ready port. REDUCT_STREAM_LAST_EN adds in_last.
module reduct_stream
  import reduct_pkg::*;
#(
  parameter logic [23:0] OPE  = OP_XOR,
  parameter logic        NOT  = `Disable,
  parameter int          IN   = 4,
  parameter int          DATA = 16,
  localparam int         CNT_W = (IN < 2) ? 1 : $clog2(IN + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA-1:0]  in_data,
`ifdef REDUCT_STREAM_LAST_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA-1:0]  out,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [IDENT_MAX_W-1:0] IDENT_FULL = identity(OPE, DATA);
  localparam logic [DATA-1:0]        IDENT      = IDENT_FULL[DATA-1:0];
  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(IN - 1);

  generate
    if (IN < 1) begin : g_bad_in
      $error("reduct_stream: IN must be >= 1");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [DATA-1:0]  acc_q, acc_d;
  logic [DATA-1:0]  out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [DATA-1:0]  fold;
  logic             accept;
  logic             last_beat;
  logic             close;

  reduct_op #(
    .OPE  (OPE),
    .DATA (DATA)
  ) u_op (
    .a (acc_q),
    .b (in_data),
    .y (fold)
  );

`ifdef REDUCT_STREAM_LAST_EN
  assign last_beat = in_last;
`else
  assign last_beat = 1'b0;
`endif

  // in_ready is gated by reset_ so it is low for the whole time reset is held.
  assign in_ready  = reset_ && (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign accept    = in_valid && in_ready;
  assign close     = accept && ((cnt_q == CNT_LAST) || last_beat);
  assign out       = out_q;
  assign out_cnt   = out_cnt_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ACC: begin
        if (close) begin
          out_d     = NOT ? ~fold : fold;
          out_cnt_d = cnt_q + 1'b1;
          acc_d     = IDENT;
          cnt_d     = '0;
          state_d   = OUT;
        end else if (accept) begin
          acc_d = fold;
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ACC;
      acc_q     <= IDENT;
      cnt_q     <= '0;
      out_q     <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_reduct_stream.sv
// Drives three reducers (xor, inverted and, or) from one shared stream and checks
// each against a software fold of the beats in the group.
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif

module tb_reduct_stream;

  localparam int IN   = 4;
  localparam int DATA = 16;
  localparam int CW   = $clog2(IN + 1);

  logic            clk = 1'b0;
  logic            reset_ = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [DATA-1:0] in_data = '0;
`ifdef REDUCT_STREAM_LAST_EN
  logic            in_last = 1'b0;
`endif

  logic            rdy_x, rdy_a, rdy_o;
  logic            vld_x, vld_a, vld_o;
  logic [DATA-1:0] out_x, out_a, out_o;
  logic [CW-1:0]   cnt_x, cnt_a, cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reduct_stream #(.OPE("xor"), .NOT(`Disable), .IN(IN), .DATA(DATA)) u_xor (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_x), .in_data(in_data),
`ifdef REDUCT_STREAM_LAST_EN
    .in_last(in_last),
`endif
    .out_valid(vld_x), .out_ready(out_ready), .out(out_x), .out_cnt(cnt_x));

  reduct_stream #(.OPE("and"), .NOT(`Enable), .IN(IN), .DATA(DATA)) u_and (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
`ifdef REDUCT_STREAM_LAST_EN
    .in_last(in_last),
`endif
    .out_valid(vld_a), .out_ready(out_ready), .out(out_a), .out_cnt(cnt_a));

  reduct_stream #(.OPE("or"), .NOT(`Disable), .IN(IN), .DATA(DATA)) u_or (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
`ifdef REDUCT_STREAM_LAST_EN
    .in_last(in_last),
`endif
    .out_valid(vld_o), .out_ready(out_ready), .out(out_o), .out_cnt(cnt_o));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA-1:0] d, input bit last, input int gap);
    int t;
    in_valid = 1'b0;
    in_data  = 'x;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
`ifdef REDUCT_STREAM_LAST_EN
    in_last  = last;
`else
    if (last) t = 0;
`endif
    t = 0;
    while (!rdy_x && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 64'(rdy_x), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
`ifdef REDUCT_STREAM_LAST_EN
    in_last  = 1'b0;
`endif
  endtask

  // Fold the group in software, stream it, then check latency, hold under stall and release.
  task automatic run_group(input string tag, input logic [DATA-1:0] b[$], input bit last_final,
                           input int gap_max, input int stall);
    logic [DATA-1:0] ex, ea, eo;
    logic [CW-1:0]   ec;
    int n;
    n  = b.size();
    ex = '0;
    ea = '1;
    eo = '0;
    for (int i = 0; i < n; i++) begin
      ex = ex ^ b[i];
      ea = ea & b[i];
      eo = eo | b[i];
    end
    ea = ~ea;
    ec = CW'(n);
    for (int i = 0; i < n; i++) begin
      send_beat(b[i], (i == n - 1) && last_final, int'($urandom_range(gap_max, 0)));
    end
    check({tag, "_latency"}, 64'({vld_x, vld_a, vld_o, rdy_x, rdy_a, rdy_o}), 64'b111000);
    check({tag, "_xor"}, 64'(out_x), 64'(ex));
    check({tag, "_and"}, 64'(out_a), 64'(ea));
    check({tag, "_or"}, 64'(out_o), 64'(eo));
    check({tag, "_cnt"}, 64'({cnt_x, cnt_a, cnt_o}), 64'({ec, ec, ec}));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_hold"}, {vld_x, rdy_x, out_x, out_a, out_o, cnt_x}, {1'b1, 1'b0, ex, ea, eo, ec});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release"}, 64'({vld_x, vld_a, vld_o, rdy_x}), 64'b0001);
    $display("group %s: beats=%0d xor=%h and=%h or=%h cnt=%0d", tag, n, out_x, out_a, out_o, cnt_x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA-1:0] q[$];
    int sz;
    bit lf;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({vld_x, rdy_x, out_x, cnt_x}), 64'd0);
    check("reset_ready_all", 64'({rdy_a, rdy_o, vld_a, vld_o}), 64'd0);
    reset_ = 1'b1;
    tick();
    check("post_reset_ready", 64'({rdy_x, rdy_a, rdy_o, vld_x}), 64'b1110);

    q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
    run_group("walk", q, 1'b0, 0, 0);
    check("walk_spec_xor", 64'(out_x), 64'h000F);

    q = '{16'hFFFF, 16'h0F0F, 16'h00FF, 16'hFFF0};
    run_group("and_inv", q, 1'b0, 0, 0);
    check("and_inv_spec", 64'(out_a), 64'hFFFF);

    q = '{16'h1000, 16'h0200, 16'h0030, 16'h0004};
    run_group("or_pack", q, 1'b0, 1, 0);
    check("or_pack_spec", 64'(out_o), 64'h1234);

    q = '{16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    run_group("backpressure", q, 1'b0, 0, 5);
    check("backpressure_spec", 64'(out_x), 64'hA5A5);

    // Reset while a result is waiting: out_valid must drop without a clock edge.
    q = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
    for (int i = 0; i < IN; i++) send_beat(q[i], 1'b0, 0);
    check("pre_reset_valid", 64'(vld_x), 64'd1);
    #2 reset_ = 1'b0;
    #1 check("async_reset_out", 64'({vld_x, vld_a, vld_o, rdy_x, out_x, cnt_x}), 64'd0);
    #1 reset_ = 1'b1;
    tick();

    // Reset mid-group: the two beats already taken must be discarded.
    send_beat(16'h00FF, 1'b0, 0);
    send_beat(16'hFF00, 1'b0, 0);
    #2 reset_ = 1'b0;
    #1 check("midgroup_reset", 64'({vld_x, rdy_x}), 64'd0);
    #1 reset_ = 1'b1;
    tick();
    q = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    run_group("after_reset", q, 1'b0, 0, 0);
    check("after_reset_spec", 64'({out_x, cnt_x}), 64'({16'h0000, 3'd4}));

`ifdef REDUCT_STREAM_LAST_EN
    q = '{16'h00F0, 16'h000F};
    run_group("early_last", q, 1'b1, 0, 1);
    check("early_last_spec", 64'({out_o, cnt_o}), 64'({16'h00FF, 3'd2}));
    q = '{16'h0100, 16'h0020, 16'h0003, 16'h4000};
    run_group("after_last", q, 1'b0, 0, 0);
    check("after_last_spec", 64'({out_o, cnt_o}), 64'({16'h4123, 3'd4}));
`endif

    for (int g = 0; g < 100; g++) begin
      sz = IN;
      lf = 1'b0;
`ifdef REDUCT_STREAM_LAST_EN
      sz = int'($urandom_range(IN, 1));
      lf = (sz < IN) || ($urandom_range(1, 0) == 1);
`endif
      q = {};
      for (int i = 0; i < sz; i++) q.push_back(DATA'($urandom));
      run_group($sformatf("rand%0d", g), q, lf, 2, int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
